// File: rtl/nes_pad_scanner.sv
// Two-pad NES controller scanner. Drives a shared latch/clock bus, samples both
// serial data lines together, commits one button frame per scan and reports
// the press/release edges of that frame relative to the previous one.
module nes_pad_scanner #(
  parameter int unsigned CLK_DIV     = 256,
  parameter int unsigned POLL_PERIOD = 524288
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       poll_req,
  input  logic       data_p1,
  input  logic       data_p2,
  output logic       pad_latch,
  output logic       pad_clock,
  output logic [7:0] buttons_p1,
  output logic [7:0] buttons_p2,
  output logic [7:0] pressed_p1,
  output logic [7:0] pressed_p2,
  output logic [7:0] released_p1,
  output logic [7:0] released_p2,
  output logic       frame_valid,
  output logic       busy
);

  localparam int unsigned TW = $clog2(POLL_PERIOD);
  localparam int unsigned CW = $clog2(2 * CLK_DIV);

  typedef enum logic [1:0] {StIdle, StLatch, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  meta_q, meta_d;   // {p2, p1} first synchronizer stage
  logic [1:0]  sync_q, sync_d;   // {p2, p1} second synchronizer stage
  logic [7:0]  shift_p1_q, shift_p1_d, shift_p2_q, shift_p2_d;
  logic        latch_q, latch_d, clock_q, clock_d, busy_q, busy_d, valid_q, valid_d;
  logic [7:0]  btn_p1_q, btn_p1_d, btn_p2_q, btn_p2_d;
  logic [7:0]  prs_p1_q, prs_p1_d, prs_p2_q, prs_p2_d;
  logic [7:0]  rel_p1_q, rel_p1_d, rel_p2_q, rel_p2_d;
  logic        auto_start;

  // Next-state logic: synchronizers, free-running poll timer and the scan FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_p1_d = shift_p1_q;
    shift_p2_d = shift_p2_q;
    latch_d    = latch_q;
    clock_d    = clock_q;
    busy_d     = busy_q;
    btn_p1_d   = btn_p1_q;
    btn_p2_d   = btn_p2_q;
    valid_d    = 1'b0;
    prs_p1_d   = 8'h00;
    prs_p2_d   = 8'h00;
    rel_p1_d   = 8'h00;
    rel_p2_d   = 8'h00;

    meta_d = {data_p2, data_p1};
    sync_d = meta_q;

    // Timer phase never depends on the FSM, so scans stay on a fixed cadence.
    auto_start = 1'b0;
    if (!enable) begin
      timer_d = '0;
    end else if (timer_q == TW'(POLL_PERIOD - 1)) begin
      timer_d    = '0;
      auto_start = 1'b1;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (enable && (auto_start || poll_req)) begin
          state_d = StLatch;
          latch_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      StLatch: begin
        if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
          state_d = StShift;
          latch_d = 1'b0;
          cnt_d   = '0;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StShift: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!clock_q) begin
            // End of low phase: data lines are active-low, store as pressed=1.
            clock_d    = 1'b1;
            shift_p1_d = {shift_p1_q[6:0], ~sync_q[0]};
            shift_p2_d = {shift_p2_q[6:0], ~sync_q[1]};
          end else begin
            clock_d = 1'b0;
            if (bit_q == 3'd7) begin
              state_d = StDone;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        state_d  = StIdle;
        busy_d   = 1'b0;
        valid_d  = 1'b1;
        btn_p1_d = shift_p1_q;
        btn_p2_d = shift_p2_q;
        prs_p1_d = shift_p1_q & ~btn_p1_q;
        prs_p2_d = shift_p2_q & ~btn_p2_q;
        rel_p1_d = ~shift_p1_q & btn_p1_q;
        rel_p2_d = ~shift_p2_q & btn_p2_q;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset clears everything, including the bus pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      meta_q     <= 2'b00;
      sync_q     <= 2'b00;
      shift_p1_q <= 8'h00;
      shift_p2_q <= 8'h00;
      latch_q    <= 1'b0;
      clock_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      btn_p1_q   <= 8'h00;
      btn_p2_q   <= 8'h00;
      prs_p1_q   <= 8'h00;
      prs_p2_q   <= 8'h00;
      rel_p1_q   <= 8'h00;
      rel_p2_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      shift_p1_q <= shift_p1_d;
      shift_p2_q <= shift_p2_d;
      latch_q    <= latch_d;
      clock_q    <= clock_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      btn_p1_q   <= btn_p1_d;
      btn_p2_q   <= btn_p2_d;
      prs_p1_q   <= prs_p1_d;
      prs_p2_q   <= prs_p2_d;
      rel_p1_q   <= rel_p1_d;
      rel_p2_q   <= rel_p2_d;
    end
  end

  assign pad_latch   = latch_q;
  assign pad_clock   = clock_q;
  assign busy        = busy_q;
  assign frame_valid = valid_q;
  assign buttons_p1  = btn_p1_q;
  assign buttons_p2  = btn_p2_q;
  assign pressed_p1  = prs_p1_q;
  assign pressed_p2  = prs_p2_q;
  assign released_p1 = rel_p1_q;
  assign released_p2 = rel_p2_q;

endmodule

// File: doc/nes_pad_scanner.md
Name: nes_pad_scanner

Overview:
- Sequencer that polls two NES pads over a shared latch/clock bus. Each pad has its own data line.
- Generates the latch and clock waveforms and samples both data lines together.
- Commits debounced-per-frame button vectors and computes press/release edge masks.
- Sits between the pad connector pins and the game logic (player movement, menu FSM), replacing a free-running single-pad reader.

Parameters:
- CLK_DIV, 256, system clocks per half-period of the pad clock; also half the latch width. Legal range 4..4096.
- POLL_PERIOD, 524288, system clocks between consecutive automatic scan starts. Must be ≥ 18*CLK_DIV+2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  allows automatic and requested polls
- poll_req  in  1  single-cycle request for an immediate scan
- data_p1  in  1  pad 1 serial data, active-low, asynchronous
- data_p2  in  1  pad 2 serial data, active-low, asynchronous
- pad_latch  out  1  shared latch to both pads
- pad_clock  out  1  shared clock to both pads
- buttons_p1  out  8  pad 1 state, 1 = pressed
- buttons_p2  out  8  pad 2 state, 1 = pressed
- pressed_p1  out  8  pad 1 rising-edge mask, valid while frame_valid=1
- pressed_p2  out  8  pad 2 rising-edge mask, valid while frame_valid=1
- released_p1  out  8  pad 1 falling-edge mask, valid while frame_valid=1
- released_p2  out  8  pad 2 falling-edge mask, valid while frame_valid=1
- frame_valid  out  1  one-cycle pulse when a new frame is committed
- busy  out  1  high from scan start through the DONE cycle

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs are 0.
  - State = IDLE; period timer = 0; shift registers = 0.
- Button bit map, in both buttons vectors and all masks:
  - [7]=A, [6]=B, [5]=Select, [4]=Start, [3]=Up, [2]=Down, [1]=Left, [0]=Right.
  - The first bit shifted out by the pad lands in bit [7].
- Input synchronisation: data_p1 and data_p2 each pass through a 2-FF synchronizer.
- Period timer:
  - Counts every cycle while enable=1; held at 0 while enable=0.
  - On reaching POLL_PERIOD-1 it wraps to 0 and raises an auto-start request.
  - The timer phase is independent of scan state.
- IDLE:
  - pad_latch=0, pad_clock=0.
  - Move to LATCH on (auto-start OR poll_req) AND enable.
  - Auto-start and poll_req in the same cycle produce exactly one scan.
- LATCH:
  - pad_latch=1 for exactly 2*CLK_DIV cycles, then go to SHIFT with bit index 0.
- SHIFT (bit index 0..7), per bit:
  - pad_clock=0 for CLK_DIV cycles.
  - On the last cycle of that low phase, shift the inverted synchronized data into each player's shift register (LSB in, shift left).
  - Then pad_clock=1 for CLK_DIV cycles.
  - After bit 7's high phase, go to DONE.
  - Eight clock pulses total.
- DONE (1 cycle):
  - buttons_pX <= shift_pX.
  - pressed_pX = shift_pX & ~buttons_pX(old).
  - released_pX = ~shift_pX & buttons_pX(old).
  - frame_valid=1; next state IDLE.
  - Masks return to 0 the following cycle.
- Scan length: 18*CLK_DIV+1 cycles, latch rise through DONE inclusive.
- busy: 1 in LATCH, SHIFT and DONE.
- poll_req or auto-start while busy: ignored, not queued.
- enable deasserted mid-scan: the scan completes and commits normally; no new scan starts afterwards.
- Reset mid-scan: all outputs drop to 0 immediately, including pad_latch and pad_clock. Previously committed buttons are lost.
- buttons_pX holds its value between frames and changes only in DONE.
- First frame after reset: pressed mask equals buttons, because the old state is 0.

Test Plan:
- Setup for all scenarios: CLK_DIV=4, POLL_PERIOD=200.
- Reset release, enable=1, no requests -> first pad_latch rise at cycle 199 after reset release (timer reaches POLL_PERIOD-1); latch high 8 cycles; 8 pad_clock pulses, each 4 low / 4 high; frame_valid pulses 73 cycles after latch rise; next latch 200 cycles after previous.
- Pad1 model drives data low only for bit slot 0 (A), pad2 drives low for slots 3 and 7 -> buttons_p1=8'h80, buttons_p2=8'h11; pressed_p1=8'h80 and pressed_p2=8'h11 on the frame_valid cycle.
- Next frame: pad1 releases A and presses Start (slot 3) -> buttons_p1=8'h10, pressed_p1=8'h10, released_p1=8'h80; the masks are 0 one cycle later.
- poll_req pulsed in IDLE with enable=1 -> pad_latch high on the next cycle. poll_req pulsed again during SHIFT -> no extra scan; exactly one frame_valid.
- enable dropped during SHIFT -> the current frame still commits; no latch for ≥3*POLL_PERIOD. poll_req with enable=0 -> ignored.
- rst_n asserted during SHIFT -> pad_clock, pad_latch, busy and buttons are 0 in the same cycle. After release, normal polling resumes from IDLE.
